// File: rtl/write_req_pkg.sv
// Shared widths, the stage-1 request record and the stage-2 outcome type
// used by the WriteReq sink.
package write_req_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    // One registered write request, as captured from the bus in stage 1.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic              valid;
    } write_req_t;

    // What stage 2 does with the request currently held in stage 1.
    typedef enum logic [1:0] {
        WR_NONE   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_DROP   = 2'd2
    } wr_kind_t;

endpackage

// File: rtl/write_req_if.sv
// WriteReq bus: a fire-and-forget byte write with no back-pressure.
interface WriteReq (
    input logic CLK,
    input logic RST
);
    import write_req_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              valid;

    modport master (
        input  CLK,
        input  RST,
        output address,
        output data,
        output valid
    );

    modport slave (
        input CLK,
        input RST,
        input address,
        input data,
        input valid
    );

endinterface

// File: rtl/write_req_sink_sat_counter.sv
// Saturating up-counter with a synchronous clear. When inc and clr land on
// the same edge the clear happens first and the increment is still counted,
// so the result is 1.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: optional clear, then increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end
        if (inc && (count_d != '1)) begin
            count_d = count_d + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/write_req_sink.sv
// Terminating responder for WriteReq. Stage 1 registers the request and
// decodes it against the window; stage 2 commits in-range bytes to local
// memory or records an out-of-range error. A host read port returns memory
// contents one edge after rd_en, forwarding the stage-1 byte when it targets
// the same offset so that every write sampled before the read edge is seen.
module write_req_sink
    import write_req_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    WriteReq.slave                       req_in,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    output logic [CNT_WIDTH-1:0]         wr_count,
    output logic [CNT_WIDTH-1:0]         err_count,
    output logic [31:0]                  err_addr,
    output logic                         err_flag,
    input  logic                         err_clr
);

    localparam int                OFF_W       = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] MEM_DEPTH_W = ADDR_W'(MEM_DEPTH);

    // Stage 1 registers
    write_req_t        s1_d;
    write_req_t        s1_q;
    logic              s1_in_range_d;
    logic              s1_in_range_q;
    logic [OFF_W-1:0]  s1_off_d;
    logic [OFF_W-1:0]  s1_off_q;
    logic [ADDR_W-1:0] s1_off_full;

    // Stage 2 control
    wr_kind_t          wr_kind;
    logic              mem_we;
    logic              err_hit;

    // Error tracking
    logic              err_flag_d;
    logic              err_flag_q;
    logic [ADDR_W-1:0] err_addr_d;
    logic [ADDR_W-1:0] err_addr_q;

    // Read port
    logic              fwd_hit;
    logic [7:0]        rd_data_d;
    logic [7:0]        rd_data_q;
    logic              rd_valid_d;
    logic              rd_valid_q;

    // Local byte storage; deliberately not reset.
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Stage 1: capture the request and decode it. Addresses below the base
    // wrap to a huge offset and fall out of range, so nothing aliases.
    always_comb begin
        s1_d.address  = req_in.address;
        s1_d.data     = req_in.data;
        s1_d.valid    = req_in.valid;
        s1_off_full   = req_in.address - ADDR_BASE;
        s1_in_range_d = (req_in.address >= ADDR_BASE) && (s1_off_full < MEM_DEPTH_W);
        s1_off_d      = s1_off_full[OFF_W-1:0];
    end

    // Stage 1 register; reset drops any pending write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q          <= '0;
            s1_in_range_q <= 1'b0;
            s1_off_q      <= '0;
        end else begin
            s1_q          <= s1_d;
            s1_in_range_q <= s1_in_range_d;
            s1_off_q      <= s1_off_d;
        end
    end

    // Stage 2: classify the held request as a commit, a drop or nothing.
    always_comb begin
        wr_kind = WR_NONE;
        if (s1_q.valid) begin
            wr_kind = s1_in_range_q ? WR_COMMIT : WR_DROP;
        end
        mem_we  = (wr_kind == WR_COMMIT);
        err_hit = (wr_kind == WR_DROP);
    end

    // Memory write port.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[s1_off_q] <= s1_q.data;
        end
    end

    // Error flag/address: a new error beats a simultaneous clear; the
    // captured address survives the clear.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            err_flag_d = 1'b0;
        end
        if (err_hit) begin
            err_flag_d = 1'b1;
            err_addr_d = s1_q.address;
        end
    end

    // Error register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Read mux: the stage-1 byte has not reached memory yet, so a matching
    // in-range entry overrides the array value.
    always_comb begin
        fwd_hit    = s1_q.valid && s1_in_range_q && (s1_off_q == rd_addr);
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = fwd_hit ? s1_q.data : mem_q[rd_addr];
        end
    end

    // Read data register; data holds between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_wr_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (mem_we),
        .clr   (1'b0),
        .count (wr_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (err_hit),
        .clr   (err_clr),
        .count (err_count)
    );

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_write_req_sink.sv
module tb_write_req_sink;
    import write_req_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;
    localparam int          CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_addr = '0;
    logic          err_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] err_count;
    logic [31:0]   err_addr;
    logic          err_flag;

    WriteReq req_if (.CLK(CLK), .RST(RST));

    write_req_sink #(
        .ADDR_BASE (BASE),
        .MEM_DEPTH (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_in    (req_if),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_count  (wr_count),
        .err_count (err_count),
        .err_addr  (err_addr),
        .err_flag  (err_flag),
        .err_clr   (err_clr)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         pend[$];          // writes sampled but not yet committed
    wr_t         w_tmp;
    logic [7:0]  m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_wr = 0;
    int          m_err = 0;
    logic [31:0] m_eaddr = '0;
    bit          m_eflag = 0;
    logic [7:0]  m_rdata = '0;
    bit          m_rknown = 1;
    bit          m_rvalid = 0;
    bit          m_hit;

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && (o < 32'(DEPTH));
    endfunction

    function automatic logic [7:0] off8(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[7:0];
    endfunction

    // A write becomes memory/counter state one edge after it is sampled;
    // a read at edge M sees every write sampled before M that survived reset.
    always @(posedge CLK) begin
        if (RST) begin
            pend.delete();
            m_wr = 0; m_err = 0; m_eaddr = '0; m_eflag = 0;
            m_rdata = '0; m_rknown = 1; m_rvalid = 0;
        end else begin
            if (rd_en) begin
                m_rvalid = 1;
                m_hit = 0;
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (!m_hit && in_win(pend[i].addr) && off8(pend[i].addr) == rd_addr) begin
                        m_rdata = pend[i].data;
                        m_rknown = 1;
                        m_hit = 1;
                    end
                end
                if (!m_hit) begin
                    m_rdata  = m_mem[rd_addr];
                    m_rknown = m_known[rd_addr];
                end
            end else begin
                m_rvalid = 0;
            end
            if (err_clr) begin
                m_err = 0;
                m_eflag = 0;
            end
            while (pend.size() > 0) begin
                w_tmp = pend.pop_front();
                if (in_win(w_tmp.addr)) begin
                    m_mem[off8(w_tmp.addr)]   = w_tmp.data;
                    m_known[off8(w_tmp.addr)] = 1;
                    if (m_wr < CMAX) m_wr++;
                end else begin
                    m_eflag = 1;
                    m_eaddr = w_tmp.addr;
                    if (m_err < CMAX) m_err++;
                end
            end
            if (req_if.valid) pend.push_back('{req_if.address, req_if.data});
        end
        #1;
        chk("m_rd_valid", 32'(rd_valid), 32'(m_rvalid));
        if (m_rknown) chk("m_rd_data", 32'(rd_data), 32'(m_rdata));
        chk("m_wr_count", 32'(wr_count), 32'(m_wr));
        chk("m_err_count", 32'(err_count), 32'(m_err));
        chk("m_err_flag", 32'(err_flag), 32'(m_eflag));
        chk("m_err_addr", err_addr, m_eaddr);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [31:0] a, input logic [7:0] d,
                       input logic re, input logic [7:0] ra, input logic ec);
        req_if.valid   = v;
        req_if.address = a;
        req_if.data    = d;
        rd_en          = re;
        rd_addr        = ra;
        err_clr        = ec;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 8'h0, 1'b0, 8'h0, 1'b0);
    endtask

    task automatic pulse_reset();
        req_if.valid = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    logic [31:0] r_addr;
    logic [7:0]  r_ra;
    int          sel;

    initial begin
        req_if.valid = 1'b0;
        req_if.address = '0;
        req_if.data = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // reset state
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_err_flag", 32'(err_flag), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);

        // basic write then read
        cyc(1'b1, BASE + 32'd3, 8'hA5, 1'b0, 8'd0, 1'b0);
        idle(2);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 8'd3, 1'b0);
        chk("t1_rd_data", 32'(rd_data), 32'hA5);
        chk("t1_rd_valid", 32'(rd_valid), 32'h1);
        chk("t1_wr_count", 32'(wr_count), 32'h1);
        idle(1);
        chk("t1_rd_valid_drop", 32'(rd_valid), 32'h0);
        chk("t1_rd_data_hold", 32'(rd_data), 32'hA5);

        // forwarding vs same-edge read
        cyc(1'b1, BASE + 32'd7, 8'h22, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, BASE + 32'd0, 8'h33, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, BASE + 32'd255, 8'h44, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, BASE + 32'd9, 8'h99, 1'b0, 8'd0, 1'b0);
        idle(1);
        cyc(1'b1, BASE + 32'd7, 8'h11, 1'b1, 8'd7, 1'b0);
        chk("t2_same_edge", 32'(rd_data), 32'h22);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 8'd7, 1'b0);
        chk("t2_forward", 32'(rd_data), 32'h11);
        chk("t2_fwd_valid", 32'(rd_valid), 32'h1);
        chk("t2_wr_count", 32'(wr_count), 32'h6);

        // out-of-range on both sides of the window
        pulse_reset();
        cyc(1'b1, 32'h0000_0FFF, 8'hEE, 1'b0, 8'd0, 1'b0);
        cyc(1'b1, 32'h0000_1100, 8'hDD, 1'b0, 8'd0, 1'b0);
        idle(1);
        chk("t3_err_count", 32'(err_count), 32'h2);
        chk("t3_err_flag", 32'(err_flag), 32'h1);
        chk("t3_err_addr", err_addr, 32'h0000_1100);
        chk("t3_wr_count", 32'(wr_count), 32'h0);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 8'd0, 1'b0);
        chk("t3_mem0", 32'(rd_data), 32'h33);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 8'd255, 1'b0);
        chk("t3_mem255", 32'(rd_data), 32'h44);

        // err_clr colliding with an error commit, then alone
        cyc(1'b1, 32'h0000_2000, 8'h00, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 8'd0, 1'b1);
        chk("t4_flag_win", 32'(err_flag), 32'h1);
        chk("t4_count_win", 32'(err_count), 32'h1);
        chk("t4_addr_win", err_addr, 32'h0000_2000);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 8'd0, 1'b1);
        chk("t4_flag_clr", 32'(err_flag), 32'h0);
        chk("t4_count_clr", 32'(err_count), 32'h0);
        chk("t4_addr_keep", err_addr, 32'h0000_2000);

        // saturation
        for (int i = 0; i < 20; i++) cyc(1'b1, BASE + 32'(16 + i), 8'(i), 1'b0, 8'd0, 1'b0);
        idle(1);
        chk("t5_sat", 32'(wr_count), 32'd15);
        idle(3);
        chk("t5_sat_hold", 32'(wr_count), 32'd15);

        // reset with a write in stage 1 and a read in flight
        pulse_reset();
        cyc(1'b1, BASE + 32'd9, 8'h77, 1'b1, 8'd9, 1'b0);
        req_if.valid = 1'b0; rd_en = 1'b0;
        RST = 1'b1;
        #1;
        chk("t6_rd_valid", 32'(rd_valid), 32'h0);
        chk("t6_wr_count", 32'(wr_count), 32'h0);
        chk("t6_err_count", 32'(err_count), 32'h0);
        chk("t6_err_flag", 32'(err_flag), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        idle(1);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 8'd9, 1'b0);
        chk("t6_not_committed", 32'(rd_data), 32'h99);
        chk("t6_wr_after", 32'(wr_count), 32'h0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: r_addr = BASE + 32'($urandom_range(0, 15));
                3, 4, 5, 6: r_addr = BASE + 32'($urandom_range(0, DEPTH - 1));
                7: r_addr = BASE - 32'($urandom_range(1, 8));
                8: r_addr = BASE + 32'(DEPTH) + 32'($urandom_range(0, 8));
                default: r_addr = $urandom();
            endcase
            r_ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            cyc(($urandom_range(0, 3) != 0), r_addr, 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), r_ra, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
